// File: rtl/demux32.sv
// Registered 1-to-4 demultiplexer: each accepted word is steered by in_sel into
// one of four single-entry output slots, each with its own handshake and delivery counter.
module demux32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] out_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on in_sel, slot state and out_ready (never on in_valid);
  // a full slot stays stable until its consumer raises out_ready.

  logic [WIDTH-1:0] slot_data [4];
  logic [3:0]       slot_valid;
  logic [CNT_W-1:0] count [4];
  logic [3:0]       drain;
  logic [3:0]       load;
  logic             acc;

  // The selected slot can take a word if it is empty or emptying this cycle.
  assign in_ready = !slot_valid[in_sel] | out_ready[in_sel];
  assign acc      = in_valid & in_ready;
  assign drain    = slot_valid & out_ready;

  always_comb begin
    load = 4'b0000;
    if (acc) load[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_valid[i] <= 1'b0;
        slot_data[i]  <= '0;
      end else if (load[i]) begin
        slot_valid[i] <= 1'b1;
        slot_data[i]  <= in_data;
      end else if (drain[i]) begin
        slot_valid[i] <= 1'b0;
      end
    end

    // Delivery counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count[i] <= '0;
      end else if (drain[i] && (count[i] != {CNT_W{1'b1}})) begin
        count[i] <= count[i] + CNT_W'(1);
      end
    end

    assign out_data[i*WIDTH +: WIDTH]  = slot_data[i];
    assign out_valid[i]                = slot_valid[i];
    assign out_count[i*CNT_W +: CNT_W] = count[i];
  end

endmodule

// File: tb/tb_demux32.sv
// Randomized and directed bench for demux32, checked against a slot-level
// reference model of the four output channels.
module tb_demux32;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0]  out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*CW-1:0] out_count;

  demux32 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each consumer currently sees, plus delivered counts.
  bit           m_full [4];
  logic [W-1:0] m_word [4];
  int           m_delivered [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_data(input int i);
    return out_data[i*W +: W];
  endfunction

  function automatic logic [CW-1:0] ch_count(input int i);
    return out_count[i*CW +: CW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = '0;
      m_delivered[i] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid%0d", i), 64'(out_valid[i]), 64'(m_full[i]));
      check($sformatf("data%0d", i), 64'(ch_data(i)), 64'(m_word[i]));
      check($sformatf("count%0d", i), 64'(ch_count(i)), 64'(m_delivered[i]));
    end
  endtask

  // Called at posedge+1; drives one cycle and checks in_ready and post-edge outputs.
  task automatic step(input bit v, input int sel, input logic [W-1:0] d,
                      input logic [3:0] ordy, output bit accepted);
    bit exp_rdy;
    in_valid  = v;
    in_sel    = 2'(sel);
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = !m_full[sel] || ordy[sel];
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    accepted = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && ordy[i]) begin
        m_delivered[i] = (m_delivered[i] < CNT_MAX) ? m_delivered[i] + 1 : CNT_MAX;
        m_full[i] = 1'b0;
      end
    end
    if (accepted) begin
      m_full[sel] = 1'b1;
      m_word[sel] = d;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    bit acc;
    bit pend_v;
    int pend_sel;
    logic [W-1:0] pend_d;

    reset = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", 64'(out_data == '0), 64'h1);
    check("rst_count", 64'(out_count == '0), 64'h1);
    check("rst_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;

    // Single word to channel 2 with all consumers stalled.
    step(1'b1, 2, 32'hDEADBEEF, 4'b0000, acc);
    check("t1_acc", 64'(acc), 64'h1);
    check("t1_valid", 64'(out_valid), 64'h4);
    check("t1_data2", 64'(ch_data(2)), 64'hDEADBEEF);

    // Channel 1 full and stalled refuses, then accepts as it drains.
    step(1'b1, 1, 32'h0BADF00D, 4'b0000, acc);
    step(1'b1, 1, 32'h11111111, 4'b0000, acc);
    check("t2_refused", 64'(acc), 64'h0);
    check("t2_held", 64'(ch_data(1)), 64'h0BADF00D);
    step(1'b1, 1, 32'h11111111, 4'b0010, acc);
    check("t2_acc", 64'(acc), 64'h1);
    check("t2_cnt1", 64'(ch_count(1)), 64'h1);
    check("t2_data1", 64'(ch_data(1)), 64'h11111111);
    check("t2_valid1", 64'(out_valid[1]), 64'h1);

    // Full-rate stream into channel 3.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3, 32'(k), 4'b1000, acc);
      check("t3_acc", 64'(acc), 64'h1);
      check("t3_word", 64'(ch_data(3)), 64'(k));
    end
    step(1'b0, 3, '0, 4'b1000, acc);
    check("t3_cnt3", 64'(ch_count(3)), 64'h8);

    // Channel 0 stalled while channel 1 traffic passes.
    step(1'b1, 0, 32'h0C0C0C0C, 4'b0000, acc);
    step(1'b1, 1, 32'hA5A5A5A5, 4'b0010, acc);
    check("t4_acc", 64'(acc), 64'h1);
    step(1'b0, 1, '0, 4'b0010, acc);
    check("t4_data0", 64'(ch_data(0)), 64'h0C0C0C0C);
    check("t4_valid0", 64'(out_valid[0]), 64'h1);

    // Saturating counter on channel 0.
    for (int k = 0; k < 300; k++) step(1'b1, 0, 32'(k + 1000), 4'b0001, acc);
    step(1'b0, 0, '0, 4'b0001, acc);
    check("t5_sat", 64'(ch_count(0)), 64'hFF);

    // Mid-operation reset discards pending words.
    step(1'b1, 0, 32'h00000A0A, 4'b0000, acc);
    step(1'b1, 3, 32'h00000B0B, 4'b0000, acc);
    reset = 1'b1;
    #1;
    check("t6_valid", 64'(out_valid), 64'h0);
    check("t6_count", 64'(out_count == '0), 64'h1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) step(1'b0, s, '0, 4'b0000, acc);

    // Randomized traffic; producer holds a refused offer until it is taken.
    pend_v = 1'b0; pend_sel = 0; pend_d = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend_v) begin
        pend_v   = ($urandom_range(0, 3) != 0);
        pend_sel = $urandom_range(0, 3);
        pend_d   = $urandom;
      end
      step(pend_v, pend_sel, pend_d, 4'($urandom_range(0, 15)), acc);
      if (acc || !pend_v) pend_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
